// File: rtl/fft_stage_sequencer.sv
// Address generator and stage sequencer for an in-place radix-2 DIT FFT.
// Optional FFT_PERF_CNT_EN adds a RUN/DRAIN cycle counter output (cycle_cnt).
module fft_stage_sequencer #(
    parameter int N      = 512,
    parameter int M      = $clog2(N),
    parameter int BF_LAT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         start,
    output logic         load_ready,
    output logic         busy,
    output logic         done,
    output logic         result_bank,
    output logic         bank_rd,
    output logic [M-1:0] rd_adr_a,
    output logic [M-1:0] rd_adr_b,
    output logic [M-2:0] twiddle_adr,
    output logic [M-1:0] wr_adr_a,
    output logic [M-1:0] wr_adr_b,
    output logic         wr_en_a,
    output logic         wr_en_b,
    output logic         wr_sel_load
`ifdef FFT_PERF_CNT_EN
    ,
    output logic [15:0]  cycle_cnt
`endif
);

    localparam int SW = (M > 2) ? $clog2(M) : 1;
    localparam int D  = 1 + BF_LAT;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam logic [M-2:0] BF_LAST = (M-1)'((N / 2) - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           rdy_q;
    logic [M:0]     load_cnt_q, load_cnt_d;
    logic           loaded_q, loaded_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [M-2:0]   bf_cnt_q, bf_cnt_d;
    logic [DW-1:0]  drain_cnt_q, drain_cnt_d;
    logic           bank_rd_q, bank_rd_d;

    logic           tag_v [D];
    logic [M-1:0]   tag_a [D];
    logic [M-1:0]   tag_b [D];

    logic           idle_like, load_acc, start_acc, issue;
    logic [M-1:0]   load_adr, b, span, mask, pos, tw_full;

    assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load_ready  = rdy_q && idle_like;
    assign load_acc    = load && load_ready;
    // load wins over start when both arrive together
    assign start_acc   = start && load_ready && loaded_q && !load;
    assign issue       = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign result_bank = ((M % 2) == 1);
    assign bank_rd     = bank_rd_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            load_cnt_q  <= '0;
            loaded_q    <= 1'b0;
            stage_q     <= '0;
            bf_cnt_q    <= '0;
            drain_cnt_q <= '0;
            bank_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            load_cnt_q  <= load_cnt_d;
            loaded_q    <= loaded_d;
            stage_q     <= stage_d;
            bf_cnt_q    <= bf_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            bank_rd_q   <= bank_rd_d;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        loaded_d    = loaded_q;
        stage_d     = stage_q;
        bf_cnt_d    = bf_cnt_q;
        drain_cnt_d = drain_cnt_q;
        bank_rd_d   = bank_rd_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_acc) begin
                    state_d = S_IDLE;
                    if (load_cnt_q[M-1:0] == '1) begin
                        load_cnt_d = '0;
                        loaded_d   = 1'b1;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                        loaded_d   = 1'b0;
                    end
                end else if (start_acc) begin
                    state_d   = S_RUN;
                    stage_d   = '0;
                    bf_cnt_d  = '0;
                    bank_rd_d = 1'b0;
                    loaded_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (bf_cnt_q == BF_LAST) begin
                    state_d     = S_DRAIN;
                    bf_cnt_d    = '0;
                    drain_cnt_d = '0;
                end else begin
                    bf_cnt_d = bf_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DW'(D - 1)) begin
                    if (stage_q == SW'(M - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                        stage_d   = stage_q + SW'(1);
                        bank_rd_d = ~bank_rd_q;
                        bf_cnt_d  = '0;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Butterfly k of stage s: insert a zero at bit s of k for the top address.
    always_comb begin
        b        = {1'b0, bf_cnt_q};
        span     = M'(1) << stage_q;
        mask     = span - M'(1);
        pos      = b & mask;
        tw_full  = pos << (SW'(M - 1) - stage_q);
        rd_adr_a    = '0;
        rd_adr_b    = '0;
        twiddle_adr = '0;
        if (issue) begin
            rd_adr_a    = ((b & ~mask) << 1) | pos;
            rd_adr_b    = (((b & ~mask) << 1) | pos) | span;
            twiddle_adr = tw_full[M-2:0];
        end
    end

    // NOTE: the tag pipe is reset so an aborted transform can never emit a stale write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) begin
                tag_v[i] <= 1'b0;
                tag_a[i] <= '0;
                tag_b[i] <= '0;
            end
        end else begin
            tag_v[0] <= issue;
            tag_a[0] <= rd_adr_a;
            tag_b[0] <= rd_adr_b;
            for (int i = 1; i < D; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_a[i] <= tag_a[i-1];
                tag_b[i] <= tag_b[i-1];
            end
        end
    end

    always_comb begin
        load_adr = '0;
        for (int i = 0; i < M; i++) load_adr[i] = load_cnt_q[M-1-i];
    end

    // Loads only happen in IDLE/DONE, where the tag pipe is already empty.
    always_comb begin
        wr_sel_load = load_acc;
        if (load_acc) begin
            wr_en_a  = 1'b1;
            wr_en_b  = 1'b0;
            wr_adr_a = load_adr;
            wr_adr_b = '0;
        end else begin
            wr_en_a  = tag_v[D-1];
            wr_en_b  = tag_v[D-1];
            wr_adr_a = tag_a[D-1];
            wr_adr_b = tag_b[D-1];
        end
    end

`ifdef FFT_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (start_acc) begin
            cycle_cnt <= '0;
        end else if (busy && (cycle_cnt != 16'hFFFF)) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

endmodule
